// File: rtl/serial_add_sched.sv
// serial_add_sched: round-robin scheduler for one shared bit-serial adder.
// Two requesters compete. The winner's operands are added LSB-first over W
// cycles, then the result is returned with a one-cycle done pulse.
// Optional build macro SERIAL_SCHED_SUB_EN adds per-requester subtract select
// inputs sub0/sub1.
module serial_add_sched #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] y0,
    input  logic         req1,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
`ifdef SERIAL_SCHED_SUB_EN
    input  logic         sub0,
    input  logic         sub1,
`endif
    output logic         ack0,
    output logic         ack1,
    output logic         busy,
    output logic [W-1:0] z,
    output logic         cout,
    output logic         done,
    output logic         done_id
);

    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   x_sh_q, x_sh_d;
    logic [W-1:0]   y_sh_q, y_sh_d;
    logic [W-1:0]   z_sh_q, z_sh_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           owner_q, owner_d;
    logic           last_q, last_d;
    logic           ack0_q, ack0_d;
    logic           ack1_q, ack1_d;
    logic [W-1:0]   z_q, z_d;
    logic           cout_q, cout_d;
    logic           done_q, done_d;
    logic           done_id_q, done_id_d;

    logic           sel;
    logic           sub_sel;
    logic [1:0]     bit_sum;

    // Register all state; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_sh_q    <= '0;
            y_sh_q    <= '0;
            z_sh_q    <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            z_q       <= '0;
            cout_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_sh_q    <= x_sh_d;
            y_sh_q    <= y_sh_d;
            z_sh_q    <= z_sh_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            z_q       <= z_d;
            cout_q    <= cout_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    // Arbitration, operand capture, serial add step and sequencing
    always_comb begin
        state_d   = state_q;
        x_sh_d    = x_sh_q;
        y_sh_d    = y_sh_q;
        z_sh_d    = z_sh_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        z_d       = z_q;
        cout_d    = cout_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;

        // With both requesting, the one not served last wins
        sel = (req0 && req1) ? ~last_q : req1;
`ifdef SERIAL_SCHED_SUB_EN
        sub_sel = sel ? sub1 : sub0;
`else
        sub_sel = 1'b0;
`endif
        bit_sum = {1'b0, x_sh_q[0]} + {1'b0, y_sh_q[0]} + {1'b0, carry_q};

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // Subtraction is x + ~y + 1: invert y, seed carry with 1
                    x_sh_d  = sel ? x1 : x0;
                    y_sh_d  = (sel ? y1 : y0) ^ {W{sub_sel}};
                    carry_d = sub_sel;
                    cnt_d   = '0;
                    owner_d = sel;
                    last_d  = sel;
                    ack0_d  = ~sel;
                    ack1_d  = sel;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                carry_d = bit_sum[1];
                z_sh_d  = {bit_sum[0], z_sh_q[W-1:1]};
                x_sh_d  = x_sh_q >> 1;
                y_sh_d  = y_sh_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    z_d       = {bit_sum[0], z_sh_q[W-1:1]};
                    cout_d    = bit_sum[1];
                    done_id_d = owner_q;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign busy    = (state_q != S_IDLE);
    assign z       = z_q;
    assign cout    = cout_q;
    assign done    = done_q;
    assign done_id = done_id_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Self-checking bench for serial_add_sched (W=4): table-driven single ops,
// hand-written multi-cycle sequences, and randomized traffic checked against
// an arithmetic/round-robin reference model.
module tb_serial_add_sched;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic         sub0 = 1'b0, sub1 = 1'b0;
    logic         ack0, ack1, busy, cout, done, done_id;
    logic [W-1:0] z;

    int errors = 0;
    int checks = 0;

    serial_add_sched #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .x0(x0), .y0(y0),
        .req1(req1), .x1(x1), .y1(y1),
`ifdef SERIAL_SCHED_SUB_EN
        .sub0(sub0), .sub1(sub1),
`endif
        .ack0(ack0), .ack1(ack1), .busy(busy), .z(z),
        .cout(cout), .done(done), .done_id(done_id)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int id; int x; int y; int sub; int ez; int ec;
    } vec_t;

    typedef struct {
        int id; int z; int c; int due;
    } exp_t;

    // One complete operation by a single requester, checking timing and result
    task automatic do_op(input int id, input int xa, input int ya, input int sb,
                         input int ez, input int ec, input string tag);
        int n, k, busyc, ack_late;
        if (id == 0) begin
            req0 = 1'b1; x0 = W'(xa); y0 = W'(ya); sub0 = (sb != 0);
        end else begin
            req1 = 1'b1; x1 = W'(xa); y1 = W'(ya); sub1 = (sb != 0);
        end
        n = 0;
        do begin
            tick(); n++;
        end while (!((id == 0) ? ack0 : ack1) && n < 20);
        check({tag, " ack"}, (id == 0) ? ack0 : ack1, 1);
        check({tag, " other ack"}, (id == 0) ? ack1 : ack0, 0);
        req0 = 1'b0; req1 = 1'b0;
        busyc = busy ? 1 : 0;
        k = 0; ack_late = 0;
        while (!done && k < 20) begin
            tick(); k++;
            if (busy) busyc++;
            if (k == 1) ack_late = (ack0 || ack1) ? 1 : 0;
        end
        check({tag, " ack width"}, ack_late, 0);
        check({tag, " latency"}, k, W);
        check({tag, " z"}, z, ez);
        check({tag, " cout"}, cout, ec);
        check({tag, " done_id"}, done_id, id);
        tick();
        check({tag, " done pulse"}, done, 0);
        check({tag, " busy cycles"}, busyc + (busy ? 1 : 0), W + 1);
        check({tag, " z held"}, z, ez);
    endtask

    // Wait for either ack; who=-1 on timeout
    task automatic wait_ack(output int who, output int n, output int dones);
        n = 0; dones = 0; who = -1;
        while (n < 30) begin
            tick(); n++;
            if (done) dones++;
            if (ack0 || ack1) begin
                who = ack1 ? 1 : 0;
                break;
            end
        end
    endtask

    task automatic wait_done(output int zz, output int cc, output int id, output int n);
        n = 0; zz = -1; cc = -1; id = -1;
        while (n < 30) begin
            tick(); n++;
            if (done) begin
                zz = z; cc = cout; id = done_id;
                break;
            end
        end
    endtask

    vec_t tbl[$];
    exp_t q[$];

    initial begin
        int who, n, nd, zz, cc, id;
        int ack_ids[4], ack_cyc[4], dz[4], did[4];
        int na, cyc, last_m, last_g, w, s;
        exp_t e;

        tbl.push_back('{0, 6, 3, 0, 9, 0});
        tbl.push_back('{1, 15, 1, 0, 0, 1});
        tbl.push_back('{1, 15, 15, 0, 14, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 8, 8, 0, 0, 1});
        tbl.push_back('{1, 7, 8, 0, 15, 0});
        tbl.push_back('{0, 9, 4, 0, 13, 0});
        tbl.push_back('{1, 10, 5, 0, 15, 0});
`ifdef SERIAL_SCHED_SUB_EN
        tbl.push_back('{0, 3, 5, 1, 14, 0});
        tbl.push_back('{0, 9, 4, 1, 5, 1});
        tbl.push_back('{1, 4, 9, 1, 11, 0});
        tbl.push_back('{1, 7, 7, 1, 0, 1});
`endif

        // Reset state
        rst = 1'b1;
        tick(); tick();
        check("reset ack0", ack0, 0);
        check("reset ack1", ack1, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset z", z, 0);
        check("reset cout", cout, 0);
        check("reset done_id", done_id, 0);
        rst = 1'b0;

        // Table-driven single operations
        foreach (tbl[i])
            do_op(tbl[i].id, tbl[i].x, tbl[i].y, tbl[i].sub, tbl[i].ez, tbl[i].ec,
                  $sformatf("vec%0d", i));
        sub0 = 1'b0; sub1 = 1'b0;

        // Both requests held from reset: strict alternation starting with 0
        rst = 1'b1;
        req0 = 1'b1; x0 = 4'd6; y0 = 4'd3;
        req1 = 1'b1; x1 = 4'd5; y1 = 4'd7;
        tick();
        rst = 1'b0;
        na = 0; nd = 0; cyc = 0;
        while (nd < 4 && cyc < 60) begin
            tick(); cyc++;
            if ((ack0 || ack1) && na < 4) begin
                ack_ids[na] = ack1 ? 1 : 0;
                ack_cyc[na] = cyc;
                na++;
            end
            if (done) begin
                dz[nd] = z; did[nd] = done_id; nd++;
                if (nd == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr ack count", na, 4);
        check("rr done count", nd, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < na) check($sformatf("rr ack%0d id", i), ack_ids[i], i % 2);
            if (i < nd) begin
                check($sformatf("rr done%0d z", i), dz[i], (i % 2 == 0) ? 9 : 12);
                check($sformatf("rr done%0d id", i), did[i], i % 2);
            end
            if (i > 0 && i < na)
                check($sformatf("rr gap%0d", i), ack_cyc[i] - ack_cyc[i-1], W + 2);
        end
        tick(); tick();

        // req1 raised mid-RUN waits for IDLE; req0 result unaffected
        req0 = 1'b1; x0 = 4'd6; y0 = 4'd3;
        wait_ack(who, n, nd);
        check("mid ack0", who, 0);
        req0 = 1'b0;
        n = 0; zz = -1; id = -1;
        tick(); tick(); n = 2;
        req1 = 1'b1; x1 = 4'd5; y1 = 4'd7;
        while (!ack1 && n < 30) begin
            tick(); n++;
            if (done) begin zz = z; id = done_id; end
        end
        check("mid ack1 delay", n, W + 2);
        check("mid op0 z", zz, 9);
        check("mid op0 id", id, 0);
        req1 = 1'b0;
        wait_done(zz, cc, id, n);
        check("mid op1 z", zz, 12);
        check("mid op1 id", id, 1);
        tick();

        // Reset mid-RUN aborts and restores round-robin pointer
        req0 = 1'b1; x0 = 4'd6; y0 = 4'd3;
        wait_ack(who, n, nd);
        check("abort ack0", who, 0);
        req0 = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort z", z, 0);
        check("abort cout", cout, 0);
        req0 = 1'b1; x0 = 4'd1; y0 = 4'd2;
        req1 = 1'b1; x1 = 4'd3; y1 = 4'd4;
        wait_ack(who, n, nd);
        check("abort no done", nd, 0);
        check("abort rr winner", who, 0);
        req0 = 1'b0;
        wait_done(zz, cc, id, n);
        check("abort op0 z", zz, 3);
        wait_ack(who, n, nd);
        check("abort next winner", who, 1);
        req1 = 1'b0;
        wait_done(zz, cc, id, n);
        check("abort op1 z", zz, 7);
        tick();
        do_op(1, 15, 1, 0, 0, 1, "post-abort");

        // Randomized traffic against a reference model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_m = 1; last_g = -100; cyc = 0;
        for (int i = 0; i < 440; i++) begin
            tick(); cyc++;
            w = -1;
            if (done) begin
                check("rnd done expected", (q.size() > 0) ? 1 : 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("rnd done time", cyc, e.due);
                    check("rnd z", z, e.z);
                    check("rnd cout", cout, e.c);
                    check("rnd done_id", done_id, e.id);
                end
            end
            if (ack0 || ack1) begin
                check("rnd single ack", (ack0 && ack1) ? 1 : 0, 0);
                w = ack1 ? 1 : 0;
                check("rnd winner requested", (w == 1) ? req1 : req0, 1);
                if (req0 && req1) check("rnd rr winner", w, 1 - last_m);
                last_m = w;
                check("rnd grant spacing", (cyc - last_g >= W + 2) ? 1 : 0, 1);
                last_g = cyc;
                s = (w == 1) ? (int'(x1) + int'(y1)) : (int'(x0) + int'(y0));
                q.push_back('{w, s % (1 << W), s / (1 << W), cyc + W});
                if (w == 1) req1 = 1'b0; else req0 = 1'b0;
            end
            if (i < 400) begin
                if (!req0 && w != 0 && ($urandom % 4) == 0) begin
                    req0 = 1'b1; x0 = W'($urandom); y0 = W'($urandom);
                end
                if (!req1 && w != 1 && ($urandom % 4) == 0) begin
                    req1 = 1'b1; x1 = W'($urandom); y1 = W'($urandom);
                end
            end
        end
        check("rnd all served", q.size(), 0);
        check("rnd req0 idle", req0, 0);
        check("rnd req1 idle", req1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
